leiwand_rv32_timer: RTL and testbench



---
 rtl/leiwand_rv32_timer.sv | 153 +++++++++++++++
 tb/tb_leiwand_rv32_timer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_timer.sv
// Memory-mapped 32-bit timer/compare peripheral: prescaler, free-running COUNT,
// COMPARE match with optional auto-reload, sticky PEND flag and maskable level irq.
module leiwand_rv32_timer #(
   parameter int unsigned         XLEN       = 32,
   parameter logic [XLEN-1:0]     BASE_ADDR  = 32'h5000_0000,
   parameter int unsigned         PRESCALE_W = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   valid,
   output logic                   ready,
   input  logic [XLEN/8-1:0]      wen,
   input  logic [XLEN-1:0]        addr,
   input  logic [XLEN-1:0]        wdata,
   output logic [XLEN-1:0]        rdata,
   output logic                   irq
);

   logic                  r_ready;
   logic [XLEN-1:0]       r_rdata;
   logic [2:0]            r_ctrl;
   logic [PRESCALE_W-1:0] r_psc;
   logic [PRESCALE_W-1:0] r_psc_cnt;
   logic [XLEN-1:0]       r_count;
   logic [XLEN-1:0]       r_compare;
   logic                  r_pend;

   logic                  w_accept;
   logic [XLEN-1:0]       w_off;
   logic [2:0]            w_idx;
   logic                  w_hit;
   logic                  w_we;
   logic                  w_wr_ctrl;
   logic                  w_wr_psc;
   logic                  w_wr_count;
   logic                  w_wr_cmp;
   logic                  w_clr_pend;
   logic [XLEN-1:0]       w_rmux;
   logic [XLEN-1:0]       w_wmerge;
   logic                  w_en;
   logic                  w_tick;
   logic                  w_match;
   logic                  w_unused;

   function automatic logic [XLEN-1:0] f_merge(
      input logic [XLEN-1:0]   old_val,
      input logic [XLEN-1:0]   new_val,
      input logic [XLEN/8-1:0] be
   );
      logic [XLEN-1:0] res;
      res = old_val;
      for (int unsigned b = 0; b < XLEN/8; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   // A request is taken only while no response is outstanding, so a held
   // valid is serviced every other cycle.
   assign w_accept = valid & ~r_ready;

   assign w_off    = addr - BASE_ADDR;
   assign w_idx    = w_off[4:2];
   assign w_hit    = (w_off[XLEN-1:5] == '0) && (w_idx <= 3'd4);
   assign w_unused = &{1'b0, w_off[1:0]};

   assign w_we       = w_accept & w_hit & (|wen);
   assign w_wr_ctrl  = w_we & (w_idx == 3'd0);
   assign w_wr_psc   = w_we & (w_idx == 3'd1);
   assign w_wr_count = w_we & (w_idx == 3'd2);
   assign w_wr_cmp   = w_we & (w_idx == 3'd3);
   assign w_clr_pend = w_we & (w_idx == 3'd4) & wen[0] & wdata[0];

   always_comb begin
      w_rmux = '0;
      if (w_hit) begin
         case (w_idx)
            3'd0:    w_rmux = XLEN'(r_ctrl);
            3'd1:    w_rmux = XLEN'(r_psc);
            3'd2:    w_rmux = r_count;
            3'd3:    w_rmux = r_compare;
            3'd4:    w_rmux = XLEN'(r_pend);
            default: w_rmux = '0;
         endcase
      end
   end

   assign w_wmerge = f_merge(w_rmux, wdata, wen);

   assign w_en    = r_ctrl[0];
   assign w_tick  = w_en & (r_psc_cnt == r_psc);
   assign w_match = w_tick & (r_count == r_compare);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ready <= w_accept;
         r_rdata <= w_accept ? w_rmux : '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ctrl    <= '0;
         r_psc     <= '0;
         r_compare <= '0;
      end else begin
         if (w_wr_ctrl) r_ctrl    <= w_wmerge[2:0];
         if (w_wr_psc)  r_psc     <= w_wmerge[PRESCALE_W-1:0];
         if (w_wr_cmp)  r_compare <= w_wmerge;
      end
   end

   // Compare uses the current PRESCALE, so a smaller new value lets a running
   // counter run on to its natural wrap before the next tick.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_psc_cnt <= '0;
      end else if (!w_en || w_tick) begin
         r_psc_cnt <= '0;
      end else begin
         r_psc_cnt <= r_psc_cnt + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (w_wr_count) begin
         r_count <= w_wmerge;
      end else if (w_tick) begin
         r_count <= (w_match && r_ctrl[1]) ? '0 : r_count + XLEN'(1);
      end
   end

   // A match in the same cycle as a W1C keeps the flag set.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pend <= 1'b0;
      end else if (w_match) begin
         r_pend <= 1'b1;
      end else if (w_clr_pend) begin
         r_pend <= 1'b0;
      end
   end

   assign ready = r_ready;
   assign rdata = r_rdata;
   assign irq   = r_pend & r_ctrl[2];

endmodule

// File: tb/tb_leiwand_rv32_timer.sv
// Self-checking bench for leiwand_rv32_timer: register table, directed timing
// sequences and a randomized bus phase checked against a per-cycle reference model.
module tb_leiwand_rv32_timer;

   localparam logic [31:0] BASE = 32'h5000_0000;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic        valid  = 1'b0;
   logic [3:0]  wen    = 4'h0;
   logic [31:0] addr   = 32'h0;
   logic [31:0] wdata  = 32'h0;
   logic        ready;
   logic [31:0] rdata;
   logic        irq;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc    = 0;
   int unsigned rdy_cyc = 0;
   bit          chk_on = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   leiwand_rv32_timer #(
      .XLEN      (32),
      .BASE_ADDR (BASE),
      .PRESCALE_W(16)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .valid (valid),
      .ready (ready),
      .wen   (wen),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state advanced once per clock from the bus inputs.
   typedef struct packed {
      logic [2:0]  ctrl;
      logic [15:0] psc;
      logic [31:0] cnt;
      logic [31:0] cmp;
      logic        pend;
      logic [15:0] pc;
      logic        ready;
      logic        was_read;
      logic [31:0] rd;
   } mst_t;

   mst_t m;

   function automatic mst_t model_next(input mst_t s, input logic v, input logic [3:0] we,
                                       input logic [31:0] a, input logic [31:0] d);
      mst_t        n;
      logic [31:0] off;
      logic [31:0] cur;
      logic [31:0] mrg;
      bit          hit, tick, match, acc;
      int unsigned idx;
      n     = s;
      off   = a - BASE;
      hit   = off < 32'h14;
      idx   = off / 4;
      tick  = s.ctrl[0] && (s.pc == s.psc);
      match = tick && (s.cnt == s.cmp);
      acc   = v && !s.ready;
      cur   = 32'h0;
      if (hit) begin
         case (idx)
            0: cur = {29'h0, s.ctrl};
            1: cur = {16'h0, s.psc};
            2: cur = s.cnt;
            3: cur = s.cmp;
            default: cur = {31'h0, s.pend};
         endcase
      end
      n.ready    = acc;
      n.was_read = acc && (we == 4'h0);
      n.rd       = acc ? cur : 32'h0;
      n.pc       = (!s.ctrl[0] || tick) ? 16'h0 : s.pc + 16'h1;
      if (tick)  n.cnt  = (match && s.ctrl[1]) ? 32'h0 : s.cnt + 32'h1;
      if (match) n.pend = 1'b1;
      if (acc && hit && we != 4'h0) begin
         mrg = cur;
         for (int b = 0; b < 4; b++) if (we[b]) mrg[8*b +: 8] = d[8*b +: 8];
         case (idx)
            0: n.ctrl = mrg[2:0];
            1: n.psc  = mrg[15:0];
            2: n.cnt  = mrg;
            3: n.cmp  = mrg;
            default: if (we[0] && d[0] && !match) n.pend = 1'b0;
         endcase
      end
      return n;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) m <= '0;
      else         m <= model_next(m, valid, wen, addr, wdata);
   end

   always @(negedge clk) begin
      if (resetn && chk_on) begin
         check("ready", 32'(ready), 32'(m.ready));
         check("irq", 32'(irq), 32'(m.pend & m.ctrl[2]));
         if (!m.ready)       check("rdata_idle", rdata, 32'h0);
         else if (m.was_read) check("rdata", rdata, m.rd);
      end
   end

   // Called at a negedge with no response outstanding; returns at an idle negedge.
   task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                      output logic [31:0] rd_v, output logic irq_v);
      valid = 1'b1; addr = a; wen = we; wdata = d;
      @(posedge clk);
      @(negedge clk);
      check("bus_ready", 32'(ready), 32'h1);
      rd_v    = rdata;
      irq_v   = irq;
      rdy_cyc = cyc;
      valid = 1'b0; wen = 4'h0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] off, input logic [3:0] we, input logic [31:0] d);
      logic [31:0] r;
      logic        q;
      bus(BASE + off, we, d, r, q);
   endtask

   task automatic rd(input logic [31:0] off, output logic [31:0] r);
      logic q;
      bus(BASE + off, 4'h0, 32'h0, r, q);
   endtask

   task automatic wait_irq(output int unsigned t);
      int unsigned n;
      n = 0;
      while (!irq && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("irq_wait", 32'(irq), 32'h1);
      t = cyc;
   endtask

   typedef struct packed {
      logic [31:0] off;
      logic [3:0]  we;
      logic [31:0] d;
      logic [31:0] roff;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [16];

   initial begin
      logic [31:0] r;
      logic        q;
      int unsigned t0, t1, t2;

      vt[0]  = '{32'h0C, 4'hF, 32'h1122_3344, 32'h0C, 32'h1122_3344};
      vt[1]  = '{32'h0C, 4'h2, 32'h0000_AB00, 32'h0C, 32'h1122_AB44};
      vt[2]  = '{32'h0C, 4'h8, 32'hFF00_0000, 32'h0C, 32'hFF22_AB44};
      vt[3]  = '{32'h04, 4'hF, 32'hDEAD_BEEF, 32'h04, 32'h0000_BEEF};
      vt[4]  = '{32'h04, 4'h4, 32'h1234_5678, 32'h04, 32'h0000_BEEF};
      vt[5]  = '{32'h04, 4'h1, 32'h0000_00AA, 32'h04, 32'h0000_BEAA};
      vt[6]  = '{32'h08, 4'hF, 32'h5566_7788, 32'h08, 32'h5566_7788};
      vt[7]  = '{32'h08, 4'h3, 32'h1234_ABCD, 32'h08, 32'h5566_ABCD};
      vt[8]  = '{32'h00, 4'hF, 32'hFFFF_FFFA, 32'h00, 32'h0000_0002};
      vt[9]  = '{32'h00, 4'hE, 32'hFFFF_FFFF, 32'h00, 32'h0000_0002};
      vt[10] = '{32'h14, 4'hF, 32'h0000_1234, 32'h14, 32'h0000_0000};
      vt[11] = '{32'h10, 4'hF, 32'hFFFF_FFFF, 32'h10, 32'h0000_0000};
      vt[12] = '{32'h100, 4'hF, 32'h0000_0001, 32'h100, 32'h0000_0000};
      vt[13] = '{32'hFFFF_FFFC, 4'hF, 32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0000};
      vt[14] = '{32'h0E, 4'hF, 32'hCAFE_F00D, 32'h0F, 32'hCAFE_F00D};
      vt[15] = '{32'h18, 4'hF, 32'h0000_0000, 32'h0C, 32'hCAFE_F00D};

      repeat (3) @(negedge clk);
      resetn = 1'b1;
      chk_on = 1'b1;

      // reset state
      for (int i = 0; i <= 16; i += 4) begin
         rd(32'(i), r);
         check("reset_read", r, 32'h0);
      end
      check("reset_irq", 32'(irq), 32'h0);

      // register table (EN stays 0)
      for (int i = 0; i < 16; i++) begin
         wr(vt[i].off, vt[i].we, vt[i].d);
         rd(vt[i].roff, r);
         check($sformatf("table%0d", i), r, vt[i].exp);
      end

      // periodic autoreload: tick every 4 clks, match on 5th tick
      wr(32'h00, 4'hF, 32'h0);
      wr(32'h08, 4'hF, 32'h0);
      wr(32'h10, 4'hF, 32'h1);
      wr(32'h04, 4'hF, 32'h3);
      wr(32'h0C, 4'hF, 32'h4);
      wr(32'h00, 4'hF, 32'h7);
      t0 = rdy_cyc;
      wait_irq(t1);
      check("first_irq_delay", t1 - t0, 32'd20);
      rd(32'h08, r);
      check("reload_count", r, 32'h0);
      bus(BASE + 32'h10, 4'h1, 32'h1, r, q);
      check("w1c_irq_low", 32'(q), 32'h0);
      wait_irq(t2);
      check("irq_period", t2 - t1, 32'd20);

      // no autoreload, wrap without flag
      wr(32'h00, 4'hF, 32'h0);
      wr(32'h10, 4'hF, 32'h1);
      wr(32'h0C, 4'hF, 32'h2);
      wr(32'h04, 4'hF, 32'h0);
      wr(32'h08, 4'hF, 32'hFFFF_FFFE);
      wr(32'h00, 4'hF, 32'h5);
      rd(32'h08, r);
      check("count_ffffffff", r, 32'hFFFF_FFFF);
      rd(32'h10, r);
      check("wrap_no_pend", r, 32'h0);
      rd(32'h08, r);
      check("count_past_match", r, 32'h3);
      rd(32'h10, r);
      check("pend_on_match", r, 32'h1);

      // COUNT write collides with a tick
      wr(32'h00, 4'hF, 32'h0);
      wr(32'h0C, 4'hF, 32'hFFFF_0000);
      wr(32'h04, 4'hF, 32'h0);
      wr(32'h00, 4'hF, 32'h1);
      wr(32'h08, 4'hF, 32'h10);
      rd(32'h08, r);
      check("count_write_wins", r, 32'h11);

      // W1C collides with a match
      wr(32'h00, 4'hF, 32'h0);
      wr(32'h08, 4'hF, 32'h0);
      wr(32'h0C, 4'hF, 32'h0);
      wr(32'h10, 4'hF, 32'h1);
      wr(32'h00, 4'hF, 32'h7);
      bus(BASE + 32'h10, 4'h1, 32'h1, r, q);
      check("set_beats_clear_irq", 32'(q), 32'h1);
      rd(32'h10, r);
      check("set_beats_clear", r, 32'h1);

      // IRQEN masks irq without touching PEND
      wr(32'h00, 4'hF, 32'h0);
      wr(32'h08, 4'hF, 32'h0);
      wr(32'h0C, 4'hF, 32'h3);
      wr(32'h10, 4'hF, 32'h1);
      wr(32'h00, 4'hF, 32'h1);
      repeat (8) @(negedge clk);
      bus(BASE + 32'h10, 4'h0, 32'h0, r, q);
      check("masked_pend", r, 32'h1);
      check("masked_irq", 32'(q), 32'h0);
      bus(BASE, 4'hF, 32'h5, r, q);
      check("unmasked_irq", 32'(q), 32'h1);

      // reset in the middle of an access
      valid = 1'b1; addr = BASE + 32'h8; wen = 4'h0;
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      valid = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i <= 16; i += 4) begin
         rd(32'(i), r);
         check("post_rst_read", r, 32'h0);
      end

      // continuously held valid
      valid = 1'b1; addr = BASE + 32'h4; wen = 4'h0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("hold_ready", 32'(ready), 32'((i % 2) == 0));
      end
      valid = 1'b0;
      repeat (2) @(negedge clk);

      // randomized bus traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int unsigned k;
         k     = $urandom_range(0, 7);
         valid = ($urandom_range(0, 2) != 0);
         wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         case (k)
            0: begin addr = BASE + 32'h00; wdata = $urandom; end
            1: begin addr = BASE + 32'h04; wdata = $urandom_range(0, 3); end
            2: begin addr = BASE + 32'h08; wdata = $urandom_range(0, 12); end
            3: begin addr = BASE + 32'h0C; wdata = $urandom_range(0, 12); end
            4: begin addr = BASE + 32'h10; wdata = $urandom; end
            5: begin addr = BASE + 32'h14; wdata = $urandom; end
            6: begin addr = BASE + 32'h0B; wdata = $urandom_range(0, 12); end
            default: begin addr = $urandom; wdata = $urandom; end
         endcase
         @(negedge clk);
      end
      valid = 1'b0; wen = 4'h0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish within 1ms");
      $fatal(1);
   end

endmodule
